// File: rtl/down_timer_pkg.sv
// Shared types and default constants for the down_timer block.
// Consumers: down_timer (top) and tick_gen (prescaler).
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: pulses tick once every PRESCALE enabled clocks; clear restarts the phase.
// Only instantiated when DOWN_TIMER_PRESCALE_EN is defined.
module tick_gen
  import down_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/down_timer.sv
// Down-counting timer with one-shot / periodic auto-reload and a one-cycle tc pulse.
// Define DOWN_TIMER_PRESCALE_EN to count on every PRESCALE-th clock instead of every clock.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             mode_r, mode_next;
  logic [WIDTH-1:0] reload_r, reload_next;
  logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  logic presc_clear;

  // Restart the prescale phase on start/stop and whenever the FSM is not left in RUN.
  assign presc_clear = start || stop || (state_next != RUN);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .clr_n(clr_n),
    .en   (state == RUN),
    .clear(presc_clear),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      count    <= '0;
      tc       <= 1'b0;
      mode_r   <= 1'b0;
      reload_r <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      tc       <= tc_next;
      mode_r   <= mode_next;
      reload_r <= reload_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    tc_next     = 1'b0;
    mode_next   = mode_r;
    reload_next = reload_r;
    if (stop) begin
      state_next = IDLE;
      count_next = '0;
    end else if (start) begin
      state_next  = RUN;
      count_next  = load_val;
      mode_next   = mode;
      reload_next = load_val;
    end else if (state == RUN && tick) begin
      if (count != '0) begin
        count_next = count - WIDTH'(1);
      end else begin
        tc_next = 1'b1;
        if (mode_r) count_next = reload_r;
        else        state_next = DONE;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have parameter: WIDTH, 4, counter width in bits (min 2).
REQ-002 SHALL have parameter: PRESCALE, 4, clocks per count tick when DOWN_TIMER_PRESCALE_EN is defined (min 2); ignored otherwise.
REQ-003 SHALL have port: clk  input  1  single clock, rising edge.
REQ-004 SHALL have port: clr_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: start  input  1  load load_val and begin counting.
REQ-006 SHALL have port: stop  input  1  abort to IDLE.
REQ-007 SHALL have port: mode  input  1  0 = one-shot, 1 = periodic auto-reload; sampled at start.
REQ-008 SHALL have port: load_val  input  WIDTH  start/reload value, sampled at start.
REQ-009 SHALL have port: count  output  WIDTH  current down-count value, registered.
REQ-010 SHALL have port: tc  output  1  terminal-count pulse, one clk wide, registered.
REQ-011 SHALL have port: busy  output  1  high in RUN.
REQ-012 SHALL have port: done  output  1  high in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy and done SHALL decode from state only.
REQ-014 SHALL, in any state, on start with stop low: count<=load_val, latch mode and load_val into internal reload registers, state<=RUN; start in RUN restarts.
REQ-015 SHALL give stop priority over start: stop high -> state<=IDLE, count<=0, tc<=0 next edge.
REQ-016 SHALL, in RUN on a tick with count!=0, decrement count by 1; no tick -> hold.
REQ-017 SHALL, in RUN on a tick with count==0, set tc<=1 for exactly one cycle; latched mode=1 -> count<=latched reload value, stay RUN; mode=0 -> state<=DONE, count holds 0.
REQ-018 SHALL deassert tc on every edge not covered by REQ-017.
REQ-019 SHALL give periodic tc spacing of (load_val+1) ticks; load_val=0 periodic -> tc on every tick.
REQ-020 SHALL hold DONE until start or stop; ignore ticks in IDLE and DONE.
REQ-021 SHALL never wrap count below 0; all arithmetic modulo WIDTH with no carry out.
REQ-022 SHALL leave load_val/mode changes during RUN without effect until the next start.

Reset
REQ-023 SHALL, on clr_n low, asynchronously force state=IDLE, count=0, tc=0, busy=0, done=0, prescaler=0, reload registers=0.
REQ-024 SHALL resume from IDLE on the first clk edge after clr_n rises; reset mid-RUN discards the count with no tc.

Configuration
REQ-025 SHALL, with DOWN_TIMER_PRESCALE_EN defined, generate tick once every PRESCALE clk cycles in RUN, prescaler cleared on start, stop and entry to DONE.
REQ-026 SHALL, with DOWN_TIMER_PRESCALE_EN undefined, tie tick high every cycle, with no prescaler logic.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/DONE) and default WIDTH/PRESCALE constants in shared package down_timer_pkg.
REQ-028 SHALL implement the prescaler as sub-module tick_gen, instantiated only under DOWN_TIMER_PRESCALE_EN.

Verification
REQ-029 SHALL cover: clr_n low mid-RUN (count=2) -> count=0, busy=0, tc=0 immediately; no tc after release.
REQ-030 SHALL cover: one-shot, load_val=3, no prescale, start 1 cycle -> count 3,2,1,0, tc high 1 cycle, then done=1, count=0 held.
REQ-031 SHALL cover: periodic, load_val=2 -> tc every 3 cycles with count 2,1,0,2,...; stop -> IDLE, count=0 next cycle.
REQ-032 SHALL cover: start and stop high in same cycle during RUN -> IDLE, count=0, no tc.
REQ-033 SHALL cover: start at count=1 in RUN with load_val=5 -> count=5 next cycle, no tc.
REQ-034 SHALL cover: DOWN_TIMER_PRESCALE_EN, PRESCALE=4, one-shot, load_val=1 -> count decrements every 4 clk; tc 8 clk after start, then done=1.
